uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_if.sv | 12 +
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_tx.sv | 143 ++++++++++++++
 tb/tb_uart_tx.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Purpose: constants, state encoding and helpers shared by the UART transmitter and receiver.
// Contents: frame constants, FSM state enum, CLKS_PER_BIT calculation.
// Notes: no logic; imported with import uart_pkg::*.
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0] ST_START_ENC  = 3'd1;
    localparam logic [2:0] ST_DATA_ENC   = 3'd2;
    localparam logic [2:0] ST_PARITY_ENC = 3'd3;
    localparam logic [2:0] ST_STOP_ENC   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_START  = ST_START_ENC,
        ST_DATA   = ST_DATA_ENC,
        ST_PARITY = ST_PARITY_ENC,
        ST_STOP   = ST_STOP_ENC
    } uart_state_e;

    // Integer division: the bit period is truncated, never rounded up.
    function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Purpose: byte-level request/status bundle between control logic and uart_tx.
// Ports: tx_start/tx_data driven by the controller; tx_busy/tx_done returned by the transmitter.
// Backpressure: controller must see tx_busy low (or tx_done) before a new tx_start is honoured.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;

    modport master (output tx_start, output tx_data, input tx_busy, input tx_done);
    modport slave  (input tx_start, input tx_data, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_baud_tick.sv
// Purpose: bit-period counter, counts 0..CLKS_PER_BIT-1 and wraps.
// Ports: clk, rst_n, clr (synchronous clear to 0), tick (high while count is at its terminal value).
// Latency: tick is a register decode, one cycle wide per period; clr has priority over counting.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int             CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// Purpose: 8N1-style UART transmitter (optional parity, 1 or 2 stop bits), LSB first.
// Ports: clk, rst_n, ctl (uart_tx_if.slave: tx_start/tx_data in, tx_busy/tx_done out), tx serial line.
// Latency: start bit on the line one cycle after accept; tx_start while busy is dropped, not queued.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD),
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave ctl,
    output logic     tx
);
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = (STOP_BITS == 2);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        tick;
    logic        parity_bit;

    // The bit timer idles at zero so every frame starts with a full start bit.
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == ST_IDLE),
        .tick  (tick)
    );

    assign parity_bit = (^shift_q) ^ (PARITY_ODD != 0);

    // tx_d is the level for the *next* state so the line itself stays a plain flop.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                tx_d   = IDLE_LEVEL;
                busy_d = 1'b0;
                if (ctl.tx_start) begin
                    shift_d    = ctl.tx_data;
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_bit;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = IDLE_LEVEL;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    tx_d    = IDLE_LEVEL;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx          = tx_q;
    assign ctl.tx_busy = busy_q;
    assign ctl.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at 4 clocks per bit: instance 0 is 8N1, 1 is even parity,
// 2 is odd parity, 3 has two stop bits. Instance 0 also feeds a line decoder
// that pops expected bytes from a scoreboard queue.
module tb_uart_tx;
    localparam int N_DUT = 4;
    localparam int CPB   = 4;
    localparam int PEN  [N_DUT] = '{0, 1, 1, 0};
    localparam int PODD [N_DUT] = '{0, 0, 1, 0};
    localparam int STOPS[N_DUT] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_r[N_DUT];
    logic [7:0] data_r [N_DUT];
    logic       tx_w   [N_DUT];
    logic       busy_w [N_DUT];
    logic       done_w [N_DUT];

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sb_q[$];
    int         frames_seen = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < N_DUT; i++) begin : g_dut
        uart_tx_if ifc();
        assign ifc.tx_start = start_r[i];
        assign ifc.tx_data  = data_r[i];
        assign busy_w[i]    = ifc.tx_busy;
        assign done_w[i]    = ifc.tx_done;

        uart_tx #(
            .CLK_FREQ_HZ (460800),
            .BAUD        (115200),
            .PARITY_EN   (PEN[i]),
            .PARITY_ODD  (PODD[i]),
            .STOP_BITS   (STOPS[i])
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .ctl   (ifc.slave),
            .tx    (tx_w[i])
        );
    end

    // Line decoder for instance 0: 40 one-per-cycle samples per frame; a reset
    // during collection abandons the frame.
    logic        mon_prev = 1'b1;
    logic        mon_act  = 1'b0;
    int          mon_n    = 0;
    logic [39:0] mon_buf;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                mon_act  = 1'b0;
                mon_prev = 1'b1;
            end else if (!mon_act) begin
                if (mon_prev && !tx_w[0]) begin
                    mon_act    = 1'b1;
                    mon_buf[0] = tx_w[0];
                    mon_n      = 1;
                end
                mon_prev = tx_w[0];
            end else begin
                mon_buf[mon_n] = tx_w[0];
                mon_n++;
                if (mon_n == 40) begin
                    logic       steady;
                    logic [7:0] got;
                    logic [7:0] exp_b;
                    mon_act  = 1'b0;
                    mon_prev = mon_buf[39];
                    frames_seen++;
                    steady = 1'b1;
                    for (int g = 0; g < 10; g++)
                        for (int c = 1; c < 4; c++)
                            if (mon_buf[4*g+c] !== mon_buf[4*g]) steady = 1'b0;
                    n_cmp++;
                    if (steady !== 1'b1) begin
                        n_bad++;
                        $display("FAIL mon_bit_width: bit not held %0d cycles, line=%b", CPB, mon_buf);
                    end
                    n_cmp++;
                    if (mon_buf[36] !== 1'b1) begin
                        n_bad++;
                        $display("FAIL mon_stop: stop bit got %b want 1", mon_buf[36]);
                    end
                    for (int b = 0; b < 8; b++) got[b] = mon_buf[4 + 4*b + 1];
                    n_cmp++;
                    if (sb_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL mon_unexpected_frame: decoded 0x%02h with nothing expected", got);
                    end else begin
                        exp_b = sb_q.pop_front();
                        if (got !== exp_b) begin
                            n_bad++;
                            $display("FAIL mon_byte: decoded 0x%02h want 0x%02h", got, exp_b);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int idx, input string tag);
        int i;
        for (i = 0; i < 200; i++) begin
            if (done_w[idx] === 1'b1) break;
            step();
        end
        n_cmp++;
        if (i == 200) begin
            n_bad++;
            $display("FAIL %s_timeout: tx_done not seen within 200 cycles", tag);
        end
    endtask

    // Cycle-exact check of one frame on instance idx, accepted in the current cycle.
    task automatic test_frame(input int idx, input logic [7:0] b, input string tag);
        int   f;
        int   g;
        logic e_tx;
        f = (1 + 8 + PEN[idx] + STOPS[idx]) * CPB;
        start_r[idx] = 1'b1;
        data_r[idx]  = b;
        if (idx == 0) sb_q.push_back(b);
        step();
        start_r[idx] = 1'b0;
        data_r[idx]  = ~b;
        for (int k = 1; k <= f + 3; k++) begin
            if (k > 1) step();
            g = (k - 1) / CPB;
            if (k > f)                       e_tx = 1'b1;
            else if (g == 0)                 e_tx = 1'b0;
            else if (g <= 8)                 e_tx = b[g-1];
            else if (g == 9 && PEN[idx] != 0) e_tx = (^b) ^ (PODD[idx] != 0);
            else                             e_tx = 1'b1;
            n_cmp++;
            if (tx_w[idx] !== e_tx) begin
                n_bad++;
                $display("FAIL %s_tx: cycle N+%0d tx=%b want %b", tag, k, tx_w[idx], e_tx);
            end
            n_cmp++;
            if (busy_w[idx] !== (k <= f)) begin
                n_bad++;
                $display("FAIL %s_busy: cycle N+%0d busy=%b want %b", tag, k, busy_w[idx], (k <= f));
            end
            n_cmp++;
            if (done_w[idx] !== (k == f + 1)) begin
                n_bad++;
                $display("FAIL %s_done: cycle N+%0d done=%b want %b", tag, k, done_w[idx], (k == f + 1));
            end
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N_DUT; i++) begin
                start_r[i] = c[0];
                data_r[i]  = 8'h5A;
            end
            step();
            for (int i = 0; i < N_DUT; i++) begin
                n_cmp++;
                if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || done_w[i] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_outputs: dut%0d tx=%b busy=%b done=%b want 1/0/0",
                             i, tx_w[i], busy_w[i], done_w[i]);
                end
            end
        end
        for (int i = 0; i < N_DUT; i++) start_r[i] = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle: tx=%b busy=%b want 1/0", tx_w[0], busy_w[0]);
            end
        end
    endtask

    task automatic test_single();
        test_frame(0, 8'h55, "single");
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL single_sb: %0d bytes left undecoded, want 0", sb_q.size());
        end
    endtask

    task automatic test_busy_reject();
        int f0;
        int busy_cnt;
        f0 = frames_seen;
        start_r[0] = 1'b1;
        data_r[0]  = 8'hA5;
        sb_q.push_back(8'hA5);
        step();
        start_r[0] = 1'b0;
        for (int c = 0; c < 12; c++) step();
        start_r[0] = 1'b1;
        data_r[0]  = 8'hFF;
        step();
        start_r[0] = 1'b0;
        wait_done(0, "reject");
        busy_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (busy_w[0] === 1'b1) busy_cnt++;
        end
        n_cmp++;
        if (busy_cnt != 0) begin
            n_bad++;
            $display("FAIL reject_no_second: busy for %0d cycles after done, want 0", busy_cnt);
        end
        n_cmp++;
        if (frames_seen - f0 != 1) begin
            n_bad++;
            $display("FAIL reject_frames: %0d frames decoded, want 1", frames_seen - f0);
        end
    endtask

    task automatic test_back_to_back();
        start_r[0] = 1'b1;
        data_r[0]  = 8'hA5;
        sb_q.push_back(8'hA5);
        step();
        start_r[0] = 1'b0;
        wait_done(0, "b2b_first");
        n_cmp++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_gap: in done cycle tx=%b busy=%b want 1/0", tx_w[0], busy_w[0]);
        end
        start_r[0] = 1'b1;
        data_r[0]  = 8'h0F;
        sb_q.push_back(8'h0F);
        step();
        start_r[0] = 1'b0;
        n_cmp++;
        if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_start: cycle after done tx=%b busy=%b want 0/1", tx_w[0], busy_w[0]);
        end
        wait_done(0, "b2b_second");
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_sb: %0d bytes left undecoded, want 0", sb_q.size());
        end
    endtask

    task automatic test_parity_stop();
        test_frame(1, 8'h07, "par_even");
        test_frame(2, 8'h07, "par_odd");
        test_frame(3, 8'h07, "stop2");
        test_frame(1, 8'hC3, "par_even_c3");
    endtask

    task automatic test_reset_mid_frame();
        int dn;
        start_r[0] = 1'b1;
        data_r[0]  = 8'hE1;
        step();
        start_r[0] = 1'b0;
        for (int c = 1; c < 18; c++) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_async: tx=%b busy=%b done=%b want 1/0/0", tx_w[0], busy_w[0], done_w[0]);
        end
        dn = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done_w[0] === 1'b1) dn++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done_w[0] === 1'b1) dn++;
        end
        n_cmp++;
        if (dn != 0) begin
            n_bad++;
            $display("FAIL midrst_done: tx_done pulsed %0d times, want 0", dn);
        end
        test_frame(0, 8'h3C, "after_rst");
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL midrst_sb: %0d bytes left undecoded, want 0", sb_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < N_DUT; i++) begin
            start_r[i] = 1'b0;
            data_r[i]  = 8'h00;
        end
        test_reset();
        test_single();
        test_busy_reject();
        test_back_to_back();
        test_parity_stop();
        test_reset_mid_frame();
        for (int c = 0; c < 5; c++) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
